// File: rtl/l2_write_buffer_pkg.sv
// Shared types for the L2 posted write buffer: line/address typedefs,
// the two FSM state encodings and the fixed master byte-select.
package l2_write_buffer_pkg;

    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_adr;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RDMISS = 2'd1,
        S_ACK    = 2'd2
    } slv_state_e;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_DRAIN = 2'd1,
        M_READ  = 2'd2
    } mst_state_e;

    localparam logic [15:0] WB_SEL_ALL = 16'hFFFF;

endpackage

// File: rtl/l2_write_buffer_wbuf_store.sv
// Entry storage for the write buffer: valid/address/data per entry, tail
// allocation, head pop, in-place coalesce and a combinational address lookup.
module wbuf_store
    import l2_write_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_i,
    input  logic [$clog2(DEPTH)-1:0]   tail_i,
    input  logic                       coal_i,
    input  logic                       pop_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic                       drain_excl_i,
    input  lc3b_line_adr               wr_adr_i,
    input  lc3b_line                   wr_dat_i,
    output lc3b_line_adr               head_adr_o,
    output lc3b_line                   head_dat_o,
    output logic                       hit_o,
    output lc3b_line                   hit_dat_o,
    output logic                       coal_ok_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    lc3b_line_adr      adr_q [DEPTH];
    lc3b_line          dat_q [DEPTH];
    logic [DEPTH-1:0]  match_s;
    logic [PTR_W-1:0]  hit_idx_s;

    // Valid bits: clear on pop, set on allocation (never the same slot in one cycle).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            if (pop_i) begin
                valid_q[head_i] <= 1'b0;
            end
            if (alloc_i) begin
                valid_q[tail_i] <= 1'b1;
            end
        end
    end

    // Payload: new line at the tail, or overwrite the matching line when coalescing.
    always_ff @(posedge clk_i) begin
        if (alloc_i) begin
            adr_q[tail_i] <= wr_adr_i;
            dat_q[tail_i] <= wr_dat_i;
        end else if (coal_i) begin
            dat_q[hit_idx_s] <= wr_dat_i;
        end
    end

    // Address match vector and index; coalescing guarantees at most one hit.
    always_comb begin
        hit_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            match_s[i] = valid_q[i] && (adr_q[i] == wr_adr_i);
            hit_idx_s  = match_s[i] ? PTR_W'(i) : hit_idx_s;
        end
    end

    assign hit_o      = |match_s;
    assign hit_dat_o  = dat_q[hit_idx_s];
    assign head_adr_o = adr_q[head_i];
    assign head_dat_o = dat_q[head_i];
    // The head line is frozen once its drain is launched, otherwise the
    // coalesced data would be silently lost when the head pops.
    assign coal_ok_o  = hit_o && !(drain_excl_i && (hit_idx_s == head_i));

endmodule

// File: rtl/l2_write_buffer.sv
// Posted write (eviction) buffer between the L2 Wishbone master and pmem.
// Dirty lines are absorbed in one cycle and drained in FIFO order; reads
// hitting a buffered line are served locally, the rest pass through.
module l2_write_buffer
    import l2_write_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [15:0]              wbs_sel_i,
    input  logic [11:0]              wbs_adr_i,
    input  logic [127:0]             wbs_dat_i,
    output logic [127:0]             wbs_dat_o,
    output logic                     wbs_ack_o,
    output logic                     wbs_rty_o,
    output logic [127:0]             wbm_dat_o,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [15:0]              wbm_sel_o,
    output logic [11:0]              wbm_adr_o,
    input  logic [127:0]             wbm_dat_i,
    input  logic                     wbm_ack_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         fwd_hit_cnt_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    slv_state_e        slv_q, slv_d;
    mst_state_e        mst_q, mst_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              ack_q, ack_d;
    lc3b_line          dat_s_q, dat_s_d;
    lc3b_line_adr      rd_adr_q, rd_adr_d;
    logic              mcyc_q, mcyc_d, mwe_q, mwe_d;
    lc3b_line_adr      madr_q, madr_d;
    lc3b_line          mdat_q, mdat_d;
    logic [CNT_W-1:0]  fwd_q, fwd_d, stall_q, stall_d;

    logic              slv_req_s, full_s, start_drain_s, drain_excl_s, pop_s;
    logic              alloc_s, coal_s, hit_s, coal_ok_s;
    lc3b_line_adr      head_adr_s;
    lc3b_line          head_dat_s, hit_dat_s;
    logic              unused_sel_s;

    assign unused_sel_s  = ^wbs_sel_i;
    assign slv_req_s     = wbs_cyc_i && wbs_stb_i;
    assign full_s        = (count_q == OCC_W'(DEPTH));
    // A pending read miss takes the bus ahead of a new drain.
    assign start_drain_s = (mst_q == M_IDLE) && (slv_q != S_RDMISS) && (count_q != '0);
    assign drain_excl_s  = (mst_q == M_DRAIN) || start_drain_s;
    assign pop_s         = (mst_q == M_DRAIN) && wbm_ack_i;

    wbuf_store #(.DEPTH(DEPTH)) u_store (
        .clk_i        (clk),
        .rst_i        (rst),
        .alloc_i      (alloc_s),
        .tail_i       (tail_q),
        .coal_i       (coal_s),
        .pop_i        (pop_s),
        .head_i       (head_q),
        .drain_excl_i (drain_excl_s),
        .wr_adr_i     (wbs_adr_i),
        .wr_dat_i     (wbs_dat_i),
        .head_adr_o   (head_adr_s),
        .head_dat_o   (head_dat_s),
        .hit_o        (hit_s),
        .hit_dat_o    (hit_dat_s),
        .coal_ok_o    (coal_ok_s)
    );

    // Slave FSM: accept writes (coalesce/allocate/stall) and serve or forward reads.
    always_comb begin
        slv_d    = slv_q;
        ack_d    = 1'b0;
        dat_s_d  = dat_s_q;
        rd_adr_d = rd_adr_q;
        alloc_s  = 1'b0;
        coal_s   = 1'b0;
        fwd_d    = fwd_q;
        stall_d  = stall_q;
        case (slv_q)
            S_IDLE: begin
                if (slv_req_s && wbs_we_i) begin
                    if (coal_ok_s) begin
                        coal_s = 1'b1;
                        slv_d  = S_ACK;
                        ack_d  = 1'b1;
                    end else if (hit_s) begin
                        slv_d = S_IDLE;  // line is draining: retry after it pops
                    end else if (!full_s) begin
                        alloc_s = 1'b1;
                        slv_d   = S_ACK;
                        ack_d   = 1'b1;
                    end else begin
                        stall_d = (stall_q == {CNT_W{1'b1}}) ? stall_q : stall_q + CNT_W'(1);
                    end
                end else if (slv_req_s) begin
                    if (hit_s) begin
                        dat_s_d = hit_dat_s;
                        fwd_d   = (fwd_q == {CNT_W{1'b1}}) ? fwd_q : fwd_q + CNT_W'(1);
                        slv_d   = S_ACK;
                        ack_d   = 1'b1;
                    end else begin
                        rd_adr_d = wbs_adr_i;
                        slv_d    = S_RDMISS;
                    end
                end else begin
                    slv_d = S_IDLE;
                end
            end
            S_RDMISS: begin
                if ((mst_q == M_READ) && wbm_ack_i) begin
                    dat_s_d = wbm_dat_i;
                    slv_d   = S_ACK;
                    ack_d   = 1'b1;
                end else begin
                    slv_d = S_RDMISS;
                end
            end
            S_ACK:   slv_d = S_IDLE;
            default: slv_d = S_IDLE;
        endcase
    end

    // Master FSM: launch reads or head drains; hold the request until pmem ACKs.
    always_comb begin
        mst_d  = mst_q;
        mcyc_d = mcyc_q;
        mwe_d  = mwe_q;
        madr_d = madr_q;
        mdat_d = mdat_q;
        case (mst_q)
            M_IDLE: begin
                if (slv_q == S_RDMISS) begin
                    mst_d  = M_READ;
                    mcyc_d = 1'b1;
                    mwe_d  = 1'b0;
                    madr_d = rd_adr_q;
                    mdat_d = '0;
                end else if (start_drain_s) begin
                    mst_d  = M_DRAIN;
                    mcyc_d = 1'b1;
                    mwe_d  = 1'b1;
                    madr_d = head_adr_s;
                    mdat_d = head_dat_s;
                end else begin
                    mst_d = M_IDLE;
                end
            end
            M_DRAIN, M_READ: begin
                if (wbm_ack_i) begin
                    mst_d  = M_IDLE;
                    mcyc_d = 1'b0;
                    mwe_d  = 1'b0;
                end else begin
                    mst_d = mst_q;
                end
            end
            default: begin
                mst_d  = M_IDLE;
                mcyc_d = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = pop_s   ? head_q + PTR_W'(1) : head_q;
        tail_d  = alloc_s ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + OCC_W'(alloc_s) - OCC_W'(pop_s);
    end

    // State, pointer, output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slv_q    <= S_IDLE;
            mst_q    <= M_IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            dat_s_q  <= '0;
            rd_adr_q <= '0;
            mcyc_q   <= 1'b0;
            mwe_q    <= 1'b0;
            madr_q   <= '0;
            mdat_q   <= '0;
            fwd_q    <= '0;
            stall_q  <= '0;
        end else begin
            slv_q    <= slv_d;
            mst_q    <= mst_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            dat_s_q  <= dat_s_d;
            rd_adr_q <= rd_adr_d;
            mcyc_q   <= mcyc_d;
            mwe_q    <= mwe_d;
            madr_q   <= madr_d;
            mdat_q   <= mdat_d;
            fwd_q    <= fwd_d;
            stall_q  <= stall_d;
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_s_q;
    assign wbs_rty_o     = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign wbm_cyc_o     = mcyc_q;
    assign wbm_stb_o     = mcyc_q;
    assign wbm_we_o      = mwe_q;
    assign wbm_adr_o     = madr_q;
    assign wbm_dat_o     = mdat_q;
    assign wbm_sel_o     = WB_SEL_ALL;
    assign occupancy_o   = count_q;
    assign fwd_hit_cnt_o = fwd_q;
    assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed bench for l2_write_buffer: table of back-to-back transactions
// against an always-ready pmem, plus hand sequences with pmem held off.
module tb_l2_write_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [15:0]  wbs_sel_i;
    logic [11:0]  wbs_adr_i;
    logic [127:0] wbs_dat_i, wbs_dat_o;
    logic         wbs_ack_o, wbs_rty_o;
    logic [127:0] wbm_dat_o, wbm_dat_i;
    logic         wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [15:0]  wbm_sel_o;
    logic [11:0]  wbm_adr_o;
    logic [1:0]   occupancy_o;
    logic [15:0]  fwd_hit_cnt_o, stall_cnt_o;

    l2_write_buffer #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_rty_o(wbs_rty_o),
        .wbm_dat_o(wbm_dat_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .occupancy_o(occupancy_o), .fwd_hit_cnt_o(fwd_hit_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         we;
        logic [11:0]  adr;
        logic [127:0] dat;
    } ev_t;

    typedef struct {
        logic         we;
        logic [11:0]  adr;
        logic [127:0] dat;
        int           exp_cyc;
        int           exp_occ;
    } vec_t;

    ev_t  log_q[$];
    ev_t  exp_q[$];
    logic pmem_hold = 1'b0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    function automatic logic [127:0] rd_pat(input logic [11:0] a);
        return {4{8'hA5, 12'h5A3, a}};
    endfunction

    function automatic ev_t mk(input logic we, input logic [11:0] a, input logic [127:0] d);
        ev_t e;
        e.we = we; e.adr = a; e.dat = d;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // pmem model: single-cycle ACK one cycle after it sees a request, unless held off
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                wbm_ack_i = 1'b0;
            end else if (wbm_ack_i) begin
                wbm_ack_i = 1'b0;
            end else if (wbm_cyc_o && wbm_stb_o && !pmem_hold) begin
                wbm_ack_i = 1'b1;
                if (wbm_we_o) begin
                    log_q.push_back(mk(1'b1, wbm_adr_o, wbm_dat_o));
                end else begin
                    wbm_dat_i = rd_pat(wbm_adr_o);
                    log_q.push_back(mk(1'b0, wbm_adr_o, wbm_dat_i));
                end
            end
        end
    end

    task automatic xfer(input logic we, input logic [11:0] adr, input logic [127:0] dat,
                        output logic [127:0] rd, output int cyc);
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wbs_ack_o && cyc < 300);
        rd = wbs_dat_o;
        chk("ack_seen", {159'd0, wbs_ack_o}, 160'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((occupancy_o != 2'd0 || wbm_cyc_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", {159'd0, (n < 300)}, 160'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_len"}, 160'(log_q.size()), 160'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk(nm, 160'(log_q[i]), 160'(exp_q[i]));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t         vt[8];
        logic [127:0] rd;
        int           cyc;

        vt[0] = '{1'b1, 12'h100, 128'hD0D0_0000_0000_0000_0000_0000_0000_0001, 1, 1};
        vt[1] = '{1'b1, 12'h100, 128'hD1D1_0000_0000_0000_0000_0000_0000_0002, 2, 1};
        vt[2] = '{1'b0, 12'h200, 128'h0, 3, 0};
        vt[3] = '{1'b1, 12'h300, 128'hD2D2_0000_0000_0000_0000_0000_0000_0003, 1, 1};
        vt[4] = '{1'b0, 12'h400, 128'h0, 3, 0};
        vt[5] = '{1'b1, 12'h500, 128'hD3D3_0000_0000_0000_0000_0000_0000_0004, 1, 1};
        vt[6] = '{1'b1, 12'h501, 128'hD4D4_0000_0000_0000_0000_0000_0000_0005, 1, 1};
        vt[7] = '{1'b1, 12'h502, 128'hD5D5_0000_0000_0000_0000_0000_0000_0006, 1, 1};

        rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 16'hFFFF; wbs_adr_i = 12'h000; wbs_dat_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_occ",   160'(occupancy_o), 160'd0);
        chk("rst_ack",   160'(wbs_ack_o), 160'd0);
        chk("rst_dats",  160'(wbs_dat_o), 160'd0);
        chk("rst_mcyc",  160'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 160'd0);
        chk("rst_madr",  160'(wbm_adr_o), 160'd0);
        chk("rst_mdat",  160'(wbm_dat_o), 160'd0);
        chk("rst_cnts",  160'({fwd_hit_cnt_o, stall_cnt_o}), 160'd0);
        chk("rst_sel",   160'(wbm_sel_o), 160'hFFFF);
        rst = 1'b0;
        @(negedge clk);

        // single write with pmem idle
        xfer(1'b1, 12'h010, 128'hAAAA, rd, cyc);
        chk("w010_lat", 160'(cyc), 160'd1);
        chk("w010_occ", 160'(occupancy_o), 160'd1);
        exp_q.push_back(mk(1'b1, 12'h010, 128'hAAAA));
        wait_empty();
        chk("w010_occ0", 160'(occupancy_o), 160'd0);
        chk_log("w010_log");

        // back-to-back table: wait behind own drain, read misses, pop+alloc same cycle
        for (int i = 0; i < 8; i++) begin
            xfer(vt[i].we, vt[i].adr, vt[i].dat, rd, cyc);
            chk($sformatf("vec%0d_lat", i), 160'(cyc), 160'(vt[i].exp_cyc));
            chk($sformatf("vec%0d_occ", i), 160'(occupancy_o), 160'(vt[i].exp_occ));
            if (!vt[i].we) chk($sformatf("vec%0d_rd", i), 160'(rd), 160'(rd_pat(vt[i].adr)));
            exp_q.push_back(mk(vt[i].we, vt[i].adr, vt[i].we ? vt[i].dat : rd_pat(vt[i].adr)));
        end
        wait_empty();
        chk_log("vec_log");
        chk("vec_stall", 160'(stall_cnt_o), 160'd0);

        // full buffer: third write stalls until the first drain is acknowledged
        pmem_hold = 1'b1;
        xfer(1'b1, 12'h001, 128'h11, rd, cyc);
        chk("full_w1_lat", 160'(cyc), 160'd1);
        xfer(1'b1, 12'h002, 128'h22, rd, cyc);
        chk("full_w2_occ", 160'(occupancy_o), 160'd2);
        fork
            xfer(1'b1, 12'h003, 128'h33, rd, cyc);
            begin
                repeat (5) @(negedge clk);
                pmem_hold = 1'b0;
            end
        join
        chk("full_w3_lat", 160'(cyc), 160'd7);
        chk("full_stall", 160'(stall_cnt_o), 160'd6);
        exp_q.push_back(mk(1'b1, 12'h001, 128'h11));
        exp_q.push_back(mk(1'b1, 12'h002, 128'h22));
        exp_q.push_back(mk(1'b1, 12'h003, 128'h33));
        wait_empty();
        chk_log("full_log");

        // read hit from the buffer
        pmem_hold = 1'b1;
        xfer(1'b1, 12'h020, 128'hA020, rd, cyc);
        xfer(1'b0, 12'h020, 128'h0, rd, cyc);
        chk("hit_lat", 160'(cyc), 160'd1);
        chk("hit_dat", 160'(rd), 160'hA020);
        chk("hit_cnt", 160'(fwd_hit_cnt_o), 160'd1);
        pmem_hold = 1'b0;
        exp_q.push_back(mk(1'b1, 12'h020, 128'hA020));
        wait_empty();
        chk_log("hit_log");

        // coalesce into a non-draining entry
        pmem_hold = 1'b1;
        xfer(1'b1, 12'h02F, 128'hE02F, rd, cyc);
        xfer(1'b1, 12'h030, 128'hA030, rd, cyc);
        xfer(1'b1, 12'h030, 128'hB030, rd, cyc);
        chk("coal_lat", 160'(cyc), 160'd1);
        chk("coal_occ", 160'(occupancy_o), 160'd2);
        pmem_hold = 1'b0;
        exp_q.push_back(mk(1'b1, 12'h02F, 128'hE02F));
        exp_q.push_back(mk(1'b1, 12'h030, 128'hB030));
        wait_empty();
        chk_log("coal_log");

        // read miss queued behind an in-flight drain, remaining entry drains after
        pmem_hold = 1'b1;
        xfer(1'b1, 12'h050, 128'hC050, rd, cyc);
        xfer(1'b1, 12'h051, 128'hF051, rd, cyc);
        fork
            xfer(1'b0, 12'h040, 128'h0, rd, cyc);
            begin
                repeat (4) @(negedge clk);
                pmem_hold = 1'b0;
            end
        join
        chk("miss_dat", 160'(rd), 160'(rd_pat(12'h040)));
        chk("miss_cnt", 160'(fwd_hit_cnt_o), 160'd1);
        exp_q.push_back(mk(1'b1, 12'h050, 128'hC050));
        exp_q.push_back(mk(1'b0, 12'h040, rd_pat(12'h040)));
        exp_q.push_back(mk(1'b1, 12'h051, 128'hF051));
        wait_empty();
        chk_log("miss_log");

        // asynchronous reset in the middle of a drain
        pmem_hold = 1'b1;
        xfer(1'b1, 12'h060, 128'h6060, rd, cyc);
        cyc = 0;
        while (!wbm_cyc_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_started", 160'(wbm_cyc_o), 160'd1);
        rst = 1'b1;
        #1;
        chk("arst_mcyc", 160'(wbm_cyc_o), 160'd0);
        chk("arst_occ",  160'(occupancy_o), 160'd0);
        chk("arst_ack",  160'(wbs_ack_o), 160'd0);
        chk("arst_cnts", 160'({fwd_hit_cnt_o, stall_cnt_o}), 160'd0);
        @(negedge clk);
        rst = 1'b0;
        pmem_hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_log", 160'(log_q.size()), 160'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/l2_write_buffer.md
Name: l2_write_buffer

Overview:
- Posted write (eviction) buffer between the L2 cache's Wishbone master port and physical memory.
- Absorbs L2 dirty-line writebacks in one cycle and drains them to pmem in the background.
- Serves L2 line reads from buffered lines on an address match; all other reads pass through to pmem.
- L2 miss service therefore does not wait behind its own eviction.

Parameters:
- DEPTH, 2: number of buffered lines (power of two, 2..8).
- CNT_W, 16: width of statistics counters.

Ports:
- clk  in  1  single clock; also drives both Wishbone interfaces.
- rst  in  1  asynchronous, active-high reset.
- wbs  wishbone.slave  -  from L2 master. Signals: CYC, STB, WE, SEL[15:0], ADR[11:0] (line address), DAT_M[127:0] in; DAT_S[127:0], ACK, RTY out.
- wbm  wishbone.master  -  to pmem. Signals: DAT_M[127:0], CYC, STB, WE, SEL[15:0], ADR[11:0] out; DAT_S[127:0], ACK in.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.
- fwd_hit_cnt  out  CNT_W  reads served from the buffer; saturates at all-ones.
- stall_cnt  out  CNT_W  cycles a write waited on full; saturates.

Behaviour:
- Reset (asynchronous, active-high):
  - All entries invalid; occupancy=0.
  - wbs.ACK=0, wbs.DAT_S=0.
  - wbm.CYC/STB/WE=0, wbm.ADR=0, wbm.DAT_M=0.
  - Counters=0.
  - Reset mid-drain drops wbm.CYC immediately; buffered data is lost.
- Storage and handshake rules:
  - Entries form a circular FIFO: head/tail pointers plus count; pointers wrap modulo DEPTH. Each entry holds {valid, adr[11:0], data[127:0]}.
  - wbs.RTY = wbs.CYC & wbs.STB & !wbs.ACK (combinational).
  - wbs.ACK is a registered one-cycle pulse. In the ACK cycle no new slave request is sampled.
  - wbm.SEL is tied to 16'hFFFF. wbm.CYC = wbm.STB. Master requests hold steady until wbm.ACK.
- Slave FSM: S_IDLE, S_RDMISS, S_ACK.
  - S_IDLE, write, address matches a valid non-draining entry: overwrite that entry's data (coalesce); -> S_ACK; occupancy unchanged.
  - S_IDLE, write, address matches the entry currently draining: wait in S_IDLE until that entry pops, then allocate.
  - S_IDLE, write, no match, not full: write at tail; occupancy+1; -> S_ACK. Latency: ACK asserted 1 cycle after the request is sampled.
  - S_IDLE, write, no match, full: stay; stall_cnt increments each cycle. Allocation happens in the cycle after the pop.
  - S_IDLE, read, address matches a valid entry: DAT_S<=entry data; fwd_hit_cnt+1; -> S_ACK. Coalescing guarantees at most one match.
  - S_IDLE, read, no match: -> S_RDMISS.
  - S_RDMISS: once the master FSM is idle, issue the read on wbm. On wbm.ACK, latch DAT_S; -> S_ACK.
  - S_ACK: ACK=1 for one cycle; -> S_IDLE.
- Master FSM: M_IDLE, M_DRAIN, M_READ.
  - Priority: an in-flight drain is never aborted. A pending read miss beats starting a new drain.
  - M_IDLE with a read miss pending: -> M_READ.
  - M_IDLE with occupancy>0: -> M_DRAIN with ADR/DAT_M taken from the head entry.
  - M_DRAIN: on wbm.ACK, pop head (head+1, occupancy-1); -> M_IDLE.
  - M_READ: on wbm.ACK -> M_IDLE.
  - Simultaneous pop and allocate in one cycle: occupancy unchanged; both pointers advance.
- Ordering: drains reach pmem in FIFO order, so pmem always ends up with the newest value per address.

Decomposition:
- lc3b_types additions: lc3b_line (128-bit) and lc3b_line_adr (12-bit) typedefs.
- Sub-module wbuf_store: entry array plus tail write, head read, per-entry coalesce write, and combinational address match vector and match index. Excludes the draining entry from coalesce.
- Both FSMs live in the top module.

Test Plan:
- Write adr 12'h010, data A, pmem idle -> ACK 1 cycle after request, occupancy 1. pmem then sees write 12'h010/A; occupancy 0.
- DEPTH=2, pmem ACK held off; writes 12'h001, 12'h002, 12'h003 -> third write sees RTY until the first drain ACK. stall_cnt = stalled cycles. Final pmem write order 001, 002, 003.
- Write 12'h020=A, then read 12'h020 before drain -> DAT_S=A, fwd_hit_cnt=1, no wbm read issued.
- Write 12'h030=A, then write 12'h030=B while 12'h030 is not head-draining -> occupancy 1, single pmem write of B.
- Read miss 12'h040 while a drain is in flight -> wbm read issued only after the drain ACK. Read data returned; a remaining entry drains afterwards.
- Assert rst during M_DRAIN -> wbm.CYC falls the same cycle (asynchronous); occupancy 0; wbs.ACK 0.
